stack_alu_cmd_sequencer: RTL and testbench

Command-side driver for the STACK_BASED_ALU interface (CLK, input_data, opcode, output_data, overflow).
- Accepts a reverse-Polish token stream over a valid/ready handshake.
- Issues one ALU opcode per accepted token.
- Tracks stack depth, catches structural errors, and returns the final popped result with an overflow flag.
- Sits between a host/command source and the stack ALU instance.

---
 rtl/stack_alu_pkg.sv | 22 ++
 rtl/stack_alu_cmd_sequencer_if.sv | 25 ++
 rtl/STACK_BASED_ALU.sv | 52 +++++
 rtl/stack_alu_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_stack_alu_cmd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_alu_pkg.sv
// Shared opcodes, token codes and FSM states for the stack ALU command path.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TOK_ADD = 2'b00;
  localparam logic [1:0] TOK_MUL = 2'b01;
  localparam logic [1:0] TOK_END = 2'b10;
  localparam logic [1:0] TOK_RSV = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    CAPTURE,
    RESULT
  } state_t;

endpackage

// File: rtl/stack_alu_cmd_sequencer_if.sv
// Token-in / result-out handshake bundle for the stack ALU sequencer.
interface stack_alu_cmd_sequencer_if #(
  parameter int N = 32
);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic [1:0]   tok_op;
  logic [N-1:0] tok_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_ovf;
  logic         res_err;

  modport master (
    output tok_valid, tok_is_op, tok_op, tok_data, res_ready,
    input  tok_ready, res_valid, res_data, res_ovf, res_err
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_op, tok_data, res_ready,
    output tok_ready, res_valid, res_data, res_ovf, res_err
  );
endinterface

// File: rtl/STACK_BASED_ALU.sv
// Stack ALU load: PUSH/POP/ADD/MUL on an 8-entry wrapping stack,
// registered output_data and signed-overflow flag.
module STACK_BASED_ALU #(
  parameter int n = 32
) (
  input  logic         CLK,
  input  logic [n-1:0] input_data,
  input  logic [2:0]   opcode,
  output logic [n-1:0] output_data,
  output logic         overflow
);
  logic [n-1:0]   stk [8];
  logic [2:0]     sp;
  logic [2:0]     t1;
  logic [2:0]     t2;
  logic [n-1:0]   a;
  logic [n-1:0]   b;
  logic [n:0]     sum;
  logic [2*n-1:0] prod;

  assign t1 = sp - 3'd1;
  assign t2 = sp - 3'd2;
  assign a  = stk[t2];
  assign b  = stk[t1];
  assign sum = {a[n-1], a} + {b[n-1], b};
  assign prod = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});

  always_ff @(posedge CLK) begin
    overflow <= 1'b0;
    case (opcode)
      3'b100: begin
        stk[t2]  <= sum[n-1:0];
        sp       <= t1;
        overflow <= sum[n] ^ sum[n-1];
      end
      3'b101: begin
        stk[t2]  <= prod[n-1:0];
        sp       <= t1;
        overflow <= prod[2*n-1:n-1] != {(n+1){prod[n-1]}};
      end
      3'b110: begin
        stk[sp] <= input_data;
        sp      <= sp + 3'd1;
      end
      3'b111: begin
        output_data <= stk[t1];
        sp          <= t1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/stack_alu_cmd_sequencer.sv
// RPN token sequencer driving a stack ALU; depth/underflow/END checks
// and the flush path are enabled by STACK_SEQ_DEPTH_CHECK_EN.
module stack_alu_cmd_sequencer #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  stack_alu_cmd_sequencer_if.slave   io,
  output logic [2:0]                 alu_opcode,
  output logic [N-1:0]               alu_data,
  input  logic [N-1:0]               alu_result,
  input  logic                       alu_ovf,
  output logic [$clog2(DEPTH+1)-1:0] depth
);
  import stack_alu_pkg::*;

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_t       state;
  logic         accept;
  logic         bad;
  logic         arith_d;
  logic         sticky;
  logic         err;
  logic         cap_wait;
  logic         res_valid_q;
  logic [N-1:0] res_data_q;

  assign io.tok_ready = (state == RUN);
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_ovf   = sticky;
  assign io.res_err   = err;
  assign accept = io.tok_valid && (state == RUN);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  always_comb begin
    bad = 1'b0;
    if (accept) begin
      if (!io.tok_is_op) begin
        bad = (depth == FULL);
      end else begin
        unique case (io.tok_op)
          TOK_ADD, TOK_MUL: bad = (depth < DW'(2));
          TOK_END:          bad = (depth != DW'(1));
          default:          bad = 1'b1;
        endcase
      end
    end
  end
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      alu_opcode  <= OP_NOP;
      alu_data    <= '0;
      depth       <= '0;
      arith_d     <= 1'b0;
      sticky      <= 1'b0;
      err         <= 1'b0;
      cap_wait    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      alu_opcode <= OP_NOP;
      // ALU flags overflow one edge after executing, two after issue
      arith_d <= (alu_opcode == OP_ADD) || (alu_opcode == OP_MUL);
      if (arith_d && alu_ovf) sticky <= 1'b1;
      case (state)
        RUN: begin
          if (accept) begin
            if (bad) begin
              err   <= 1'b1;
              state <= FLUSH;
            end else if (!io.tok_is_op) begin
              alu_opcode <= OP_PUSH;
              alu_data   <= io.tok_data;
              if (depth != FULL) depth <= depth + 1'b1;
            end else begin
              unique case (io.tok_op)
                TOK_ADD, TOK_MUL: begin
                  alu_opcode <= (io.tok_op == TOK_ADD) ? OP_ADD : OP_MUL;
                  if (depth != '0) depth <= depth - 1'b1;
                end
                TOK_END: begin
                  alu_opcode <= OP_POP;
                  depth      <= '0;
                  cap_wait   <= 1'b0;
                  state      <= CAPTURE;
                end
                default: ;
              endcase
            end
          end
        end
        FLUSH: begin
          if (depth != '0) begin
            alu_opcode <= OP_POP;
            depth      <= depth - 1'b1;
          end else begin
            res_data_q  <= '0;
            res_valid_q <= 1'b1;
            state       <= RESULT;
          end
        end
        CAPTURE: begin
          // first edge lets the ALU execute the POP
          if (!cap_wait) begin
            cap_wait <= 1'b1;
          end else begin
            res_data_q  <= alu_result;
            res_valid_q <= 1'b1;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (io.res_ready) begin
            res_valid_q <= 1'b0;
            sticky      <= 1'b0;
            err         <= 1'b0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_alu_cmd_sequencer.sv
// Bench for stack_alu_cmd_sequencer: vector table, hand sequences and
// random RPN expressions checked against a queue-based stack model.
module tb_stack_alu_cmd_sequencer;
  import stack_alu_pkg::*;

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        is_op;
    logic [1:0]  op;
    logic [31:0] data;
  } tok_t;

  typedef struct {
    tok_t        t[12];
    int          n;
    logic [31:0] d;
    bit          ovf;
    bit          err;
    bit          chk_d;
    bit          hold;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_data;
  logic [31:0] alu_result;
  logic        alu_ovf;
  logic [3:0]  depth;

  stack_alu_cmd_sequencer_if #(.N(32)) ifc ();

  stack_alu_cmd_sequencer #(.N(32), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .io         (ifc.slave),
    .alu_opcode (alu_opcode),
    .alu_data   (alu_data),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .depth      (depth)
  );

  STACK_BASED_ALU #(.n(32)) alu (
    .CLK         (CLK),
    .input_data  (alu_data),
    .opcode      (alu_opcode),
    .output_data (alu_result),
    .overflow    (alu_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  tok_t        tq[$];
  logic [2:0]  opq[$];
  logic [2:0]  m_ops[$];
  logic [31:0] m_data;
  bit          m_ovf, m_err, m_unk;
  logic [31:0] g_data;
  bit          g_ovf, g_err;
  vec_t        tbl[12];
  int          nv;

  always @(negedge CLK)
    if (!RST && alu_opcode != OP_NOP) opq.push_back(alu_opcode);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic tok_t O(input logic [31:0] d);
    tok_t r;
    r.is_op = 1'b0;
    r.op = 2'b00;
    r.data = d;
    return r;
  endfunction

  function automatic tok_t P(input logic [1:0] op);
    tok_t r;
    r.is_op = 1'b1;
    r.op = op;
    r.data = 32'h0;
    return r;
  endfunction

  task automatic pt(input tok_t x);
    tbl[nv].t[tbl[nv].n] = x;
    tbl[nv].n++;
  endtask

  task automatic ex(input logic [31:0] d, input bit ovf, input bit err,
                    input bit chk_d, input bit hold);
    tbl[nv].d = d;
    tbl[nv].ovf = ovf;
    tbl[nv].err = err;
    tbl[nv].chk_d = chk_d;
    tbl[nv].hold = hold;
    nv++;
    tbl[nv].n = 0;
  endtask

  // Reference: evaluate the token list on an abstract stack
  task automatic model();
    logic [31:0] st[$];
    logic signed [31:0] a, b, lo;
    longint r;
    m_ops.delete();
    m_ovf = 0; m_err = 0; m_unk = 0; m_data = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if (!tq[i].is_op) begin
        if (st.size() == DEPTH) begin
          if (CHK) begin m_err = 1; break; end
          void'(st.pop_front());
        end
        st.push_back(tq[i].data);
        m_ops.push_back(OP_PUSH);
      end else if (tq[i].op == TOK_ADD || tq[i].op == TOK_MUL) begin
        if (st.size() < 2) begin
          if (CHK) begin m_err = 1; break; end
          m_unk = 1;
          if (st.size() > 0) void'(st.pop_back());
        end else begin
          b = st.pop_back();
          a = st.pop_back();
          if (tq[i].op == TOK_ADD) r = longint'(a) + longint'(b);
          else r = longint'(a) * longint'(b);
          lo = r[31:0];
          if (longint'(lo) != r) m_ovf = 1;
          st.push_back(lo);
        end
        m_ops.push_back(tq[i].op == TOK_ADD ? OP_ADD : OP_MUL);
      end else if (tq[i].op == TOK_END) begin
        if (CHK && st.size() != 1) begin m_err = 1; break; end
        m_ops.push_back(OP_POP);
        if (st.size() == 0) m_unk = 1;
        else m_data = st[$];
        st.delete();
        break;
      end else begin
        if (CHK) begin m_err = 1; break; end
      end
    end
    if (m_err) begin
      repeat (st.size()) m_ops.push_back(OP_POP);
      m_data = 0;
    end
  endtask

  task automatic drive_tok(input tok_t x);
    ifc.tok_valid = 1'b1;
    ifc.tok_is_op = x.is_op;
    ifc.tok_op    = x.op;
    ifc.tok_data  = x.data;
  endtask

  task automatic run_expr(input bit hold);
    bit broke;
    bit got;
    model();
    opq.delete();
    ifc.res_ready = !hold;
    broke = 0;
    for (int i = 0; i < tq.size(); i++) begin
      @(negedge CLK);
      if (!ifc.tok_ready) begin broke = 1; break; end
      drive_tok(tq[i]);
    end
    if (!broke) @(negedge CLK);
    ifc.tok_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 64; c++) begin
      if (ifc.res_valid) begin got = 1; break; end
      @(negedge CLK);
    end
    chk("res_seen", 32'(got), 32'd1);
    g_data = ifc.res_data;
    g_ovf  = ifc.res_ovf;
    g_err  = ifc.res_err;
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge CLK);
        chk("hold_valid", 32'(ifc.res_valid), 32'd1);
        chk("hold_data", ifc.res_data, g_data);
        chk("hold_ready", 32'(ifc.tok_ready), 32'd0);
      end
      ifc.res_ready = 1'b1;
    end
    @(negedge CLK);
    chk("res_one_cycle", 32'(ifc.res_valid), 32'd0);
    chk("depth_zero", 32'(depth), 32'd0);
    chk("ops_len", opq.size(), m_ops.size());
    if (opq.size() == m_ops.size())
      for (int i = 0; i < m_ops.size(); i++)
        chk("ops_seq", 32'(opq[i]), 32'(m_ops[i]));
  endtask

  task automatic gen_rand();
    int k, pushed, d;
    logic [31:0] v;
    tq.delete();
    k = $urandom_range(1, 5);
    pushed = 0;
    d = 0;
    while (!(pushed == k && d == 1)) begin
      if (pushed < k && (d < 2 || $urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 2))
          0: v = 32'($urandom_range(0, 1000));
          1: v = $urandom();
          default: v = 32'h7fff_0000 + 32'($urandom_range(0, 65535));
        endcase
        tq.push_back(O(v));
        pushed++;
        d++;
      end else begin
        tq.push_back(P($urandom_range(0, 1) == 1 ? TOK_MUL : TOK_ADD));
        d--;
      end
    end
    tq.push_back(P(TOK_END));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    ifc.tok_valid = 1'b0;
    ifc.tok_is_op = 1'b0;
    ifc.tok_op    = 2'b00;
    ifc.tok_data  = 32'h0;
    ifc.res_ready = 1'b1;
    #12;
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_data", alu_data, 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_data", ifc.res_data, 32'd0);
    chk("rst_res_ovf", 32'(ifc.res_ovf), 32'd0);
    chk("rst_res_err", 32'(ifc.res_err), 32'd0);
    chk("rst_tok_ready", 32'(ifc.tok_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    nv = 0;
    tbl[0].n = 0;
    pt(O(14)); pt(O(717)); pt(P(TOK_ADD)); pt(P(TOK_END));
    ex(731, 0, 0, 1, 0);
    pt(O(3)); pt(O(4)); pt(P(TOK_MUL)); pt(O(5)); pt(P(TOK_ADD));
    pt(P(TOK_END));
    ex(17, 0, 0, 1, 0);
    pt(O(32'h7fff_ffff)); pt(O(1)); pt(P(TOK_ADD)); pt(P(TOK_END));
    ex(32'h8000_0000, 1, 0, 1, 0);
    pt(O(2)); pt(P(TOK_END));
    ex(2, 0, 0, 1, 0);
    pt(O(5)); pt(P(TOK_ADD)); pt(P(TOK_END));
    ex(0, 0, CHK, CHK, 0);
    for (int i = 1; i <= 9; i++) pt(O(32'(i)));
    pt(P(TOK_END));
    ex(CHK ? 32'd0 : 32'd9, 0, CHK, 1, 1);
    pt(O(1)); pt(P(TOK_RSV)); pt(P(TOK_END));
    ex(CHK ? 32'd0 : 32'd1, 0, CHK, 1, 0);
    pt(O(1)); pt(O(2)); pt(P(TOK_END));
    ex(CHK ? 32'd0 : 32'd2, 0, CHK, 1, 0);
    pt(O(32'h1_0000)); pt(O(32'h1_0000)); pt(P(TOK_MUL)); pt(P(TOK_END));
    ex(0, 1, 0, 1, 0);
    pt(O(32'h7fff_ffff)); pt(O(1)); pt(P(TOK_ADD)); pt(O(3));
    pt(P(TOK_ADD)); pt(P(TOK_END));
    ex(32'h8000_0003, 1, 0, 1, 0);

    for (int v = 0; v < nv; v++) begin
      tq.delete();
      for (int j = 0; j < tbl[v].n; j++) tq.push_back(tbl[v].t[j]);
      run_expr(tbl[v].hold);
      chk($sformatf("vec%0d_err", v), 32'(g_err), 32'(tbl[v].err));
      if (tbl[v].chk_d) begin
        chk($sformatf("vec%0d_data", v), g_data, tbl[v].d);
        chk($sformatf("vec%0d_ovf", v), 32'(g_ovf), 32'(tbl[v].ovf));
      end
    end

    // asynchronous reset between edges with three entries stacked
    @(negedge CLK); drive_tok(O(10));
    @(negedge CLK); drive_tok(O(20));
    @(negedge CLK); drive_tok(O(30));
    @(posedge CLK);
    #1;
    chk("pre_rst_depth", 32'(depth), 32'd3);
    chk("pre_rst_opcode", 32'(alu_opcode), 32'(OP_PUSH));
    #2;
    ifc.tok_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("async_rst_opcode", 32'(alu_opcode), 32'd0);
    chk("async_rst_depth", 32'(depth), 32'd0);
    chk("async_rst_valid", 32'(ifc.res_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tq.delete();
    tq.push_back(O(7));
    tq.push_back(P(TOK_END));
    run_expr(0);
    chk("post_rst_data", g_data, 32'd7);
    chk("post_rst_err", 32'(g_err), 32'd0);

    for (int n = 0; n < 25; n++) begin
      gen_rand();
      run_expr(0);
      chk("rand_err", 32'(g_err), 32'(m_err));
      if (!m_unk) begin
        chk("rand_data", g_data, m_data);
        chk("rand_ovf", 32'(g_ovf), 32'(m_ovf));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
